// File: rtl/muldiv_iter.sv
// muldiv_iter: multi-cycle RV32M multiply/divide unit.
// A shift-add multiplier and a restoring divider share one set of operand
// registers and retire UNROLL bits per cycle. Division by zero and signed
// overflow bypass the iteration and answer on the accept edge.
// Legal configurations: XLEN even and >= 8, UNROLL in {1,2,4,8} dividing XLEN.
module muldiv_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam int ITERS = XLEN / UNROLL;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    op_t               op;
    logic              neg;      // result must be negated at the end
    logic [XLEN-1:0]   mag_a;    // multiplicand magnitude
    logic [XLEN-1:0]   mag_b;    // multiplier / divisor magnitude
    logic [2*XLEN-1:0] acc;      // product, or quotient in the low half
    logic [XLEN-1:0]   rem;      // divider remainder between iterations
    logic [CW-1:0]     count;

    // Accept-edge decode of the incoming request.
    op_t             op_in;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            neg_in;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    // Operand magnitudes, result sign and fast-path detection for the request.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        op_in    = op_t'(op_i);
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        neg_in   = 1'b0;
        fast_res = '0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                a_neg = a_i[XLEN-1];
                b_neg = b_i[XLEN-1];
            end
            OP_MULHSU: a_neg = a_i[XLEN-1];
            default: ;
        endcase
        abs_a = a_neg ? -a_i : a_i;
        abs_b = b_neg ? -b_i : b_i;
        case (op_in)
            OP_MULH, OP_MULHSU, OP_DIV: neg_in = a_neg ^ b_neg;
            OP_REM:                     neg_in = a_neg;
            default:                    neg_in = 1'b0;
        endcase
        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (a_i == MOST_NEG) && (b_i == '1);
        if (div_zero)
            fast_res = op_i[1] ? a_i : '1;
        else if (div_ovf)
            fast_res = op_i[1] ? '0 : a_i;
    end

    // Next-iteration values for both datapaths.
    logic [2*XLEN-1:0] mul_acc_n;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   div_q_n;
    logic [XLEN-1:0]   div_rem_n;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;

    // Retire UNROLL multiplier bits and UNROLL quotient bits.
    always_comb begin
        mul_acc_n = acc;
        mul_sum   = '0;
        div_q_n   = acc[XLEN-1:0];
        div_rem_n = rem;
        div_shift = '0;
        div_trial = '0;
        for (int i = 0; i < UNROLL; i++) begin
            mul_sum   = {1'b0, mul_acc_n[2*XLEN-1:XLEN]} +
                        (mul_acc_n[0] ? {1'b0, mag_a} : '0);
            mul_acc_n = {mul_sum, mul_acc_n[XLEN-1:1]};
            div_shift = {div_rem_n, div_q_n[XLEN-1]};
            div_trial = div_shift - {1'b0, mag_b};
            div_q_n   = {div_q_n[XLEN-2:0], ~div_trial[XLEN]};
            div_rem_n = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        end
    end

    // Sign correction and result selection once iteration is complete.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd  = neg ? -rem : rem;
        case (op)
            OP_MUL:                       final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo;
            default:                      final_res = rmd;
        endcase
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: all datapath registers are reset too, so no X can reach res_o after reset.
        if (rst) begin
            state        <= IDLE;
            op           <= OP_MUL;
            neg          <= 1'b0;
            mag_a        <= '0;
            mag_b        <= '0;
            acc          <= '0;
            rem          <= '0;
            count        <= '0;
            res_o        <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!kill_i && req_valid_i) begin
                        op          <= op_in;
                        neg         <= neg_in;
                        mag_a       <= abs_a;
                        mag_b       <= abs_b;
                        acc         <= {{XLEN{1'b0}}, (op_i[2] ? abs_a : abs_b)};
                        rem         <= '0;
                        count       <= CW'(ITERS);
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (div_zero || div_ovf) begin
                            res_o        <= fast_res;
                            resp_valid_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (kill_i) begin
                        state       <= IDLE;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else if (count != '0) begin
                        acc   <= op[2] ? {acc[2*XLEN-1:XLEN], div_q_n} : mul_acc_n;
                        rem   <= div_rem_n;
                        count <= count - CW'(1);
                    end else begin
                        res_o        <= final_res;
                        resp_valid_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (kill_i || resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        busy_o       <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule
